// File: rtl/shared_pkg.sv
// Shared widths and state encoding for the FIFO stream reader slice.
// Imported by the reader top module and its testbench.
package Shared_pkg;

   localparam int FIFO_WIDTH = 16;
   localparam int BUF_DEPTH  = 2;
   localparam int CNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } reader_state_e;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read-side and stream-side signals of the reader, bundled for port use.
// master = reader side, slave = FIFO plus stream sink side.
interface fifo_stream_reader_if #(
   parameter int FIFO_WIDTH = Shared_pkg::FIFO_WIDTH
);

   logic                  fifo_rd_en;
   logic [FIFO_WIDTH-1:0] fifo_data_out;
   logic                  fifo_empty;
   logic                  fifo_underflow;
   logic [FIFO_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;

   modport master (
      output fifo_rd_en, m_data, m_valid,
      input  fifo_data_out, fifo_empty, fifo_underflow, m_ready
   );

   modport slave (
      input  fifo_rd_en, m_data, m_valid,
      output fifo_data_out, fifo_empty, fifo_underflow, m_ready
   );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO-ordered output buffer: head register feeds the stream,
// tail register absorbs the word that arrives while the sink stalls.
module stream_skid_buf #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [1:0]       occ_o
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       occ_q, occ_d;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      case ({push_i, pop_i})
         2'b10: begin
            if (occ_q == 2'd0) head_d = data_i;
            else               tail_d = data_i;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd2) begin
               head_d = tail_q;
               tail_d = data_i;
            end else begin
               head_d = data_i;
            end
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   // NOTE: data registers are reset too, so the head reads 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign head_o = head_q;
   assign occ_o  = occ_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !pop_i && (occ_q == 2'd2)));

   a_no_underrun: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop_i && (occ_q == 2'd0)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream through a 2-entry
// buffer, counting transfers and flagging FIFO underflow responses.
module fifo_stream_reader
   import Shared_pkg::*;
#(
   parameter int FIFO_WIDTH = Shared_pkg::FIFO_WIDTH,
   parameter int BUF_DEPTH  = Shared_pkg::BUF_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   fifo_stream_reader_if.master bus,
   output logic [CNT_WIDTH-1:0] rd_count,
   output logic                 err_underflow,
   output logic                 busy
);

   if (BUF_DEPTH != 2) begin : g_depth_check
      $error("fifo_stream_reader supports BUF_DEPTH == 2 only");
   end

   reader_state_e        state_q, state_d;
   logic                 inflight_q;
   logic                 err_q, err_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]           occ;
   logic                 pop;
   logic                 push;
   logic                 rd_en;
   logic [2:0]           room_sum;

   assign pop  = bus.m_valid && bus.m_ready;
   assign push = inflight_q && !bus.fifo_underflow;

   // Words already committed to the buffer once this cycle's pop is taken out.
   assign room_sum = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: if (enable) state_d = RUN;
         RUN: begin
            rd_en = enable && !bus.fifo_empty && (room_sum < 3'd2);
            if (!enable) state_d = STOP;
         end
         STOP: begin
            if (enable)                               state_d = RUN;
            else if (!inflight_q && (occ == 2'd0))    state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign err_d = err_q || (inflight_q && bus.fifo_underflow);
   assign cnt_d = cnt_q + CNT_WIDTH'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= rd_en;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   stream_skid_buf #(
      .WIDTH (FIFO_WIDTH)
   ) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push),
      .data_i (bus.fifo_data_out),
      .pop_i  (pop),
      .head_o (bus.m_data),
      .occ_o  (occ)
   );

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (occ != 2'd0);
   assign rd_count       = cnt_q;
   assign err_underflow  = err_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural 1-cycle FIFO, stream
// monitor, and hand-computed expectations for each scenario.
module tb_fifo_stream_reader;
   import Shared_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] rd_count;
   logic        err_underflow;
   logic        busy;

   fifo_stream_reader_if #(.FIFO_WIDTH(FIFO_WIDTH)) bus ();

   fifo_stream_reader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .bus           (bus),
      .rd_count      (rd_count),
      .err_underflow (err_underflow),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // FIFO model: a read sampled in cycle t answers in cycle t+1.
   logic [15:0] fifo_q[$];
   logic        hold_empty = 1'b0;
   logic        force_uf   = 1'b0;
   logic        rd_seen;

   initial begin
      bus.fifo_empty     = 1'b1;
      bus.fifo_underflow = 1'b0;
      bus.fifo_data_out  = '0;
      forever begin
         @(negedge clk);
         rd_seen = bus.fifo_rd_en;
         @(posedge clk);
         #2;
         if (rd_seen) begin
            if (fifo_q.size() > 0) begin
               bus.fifo_data_out  = fifo_q.pop_front();
               bus.fifo_underflow = force_uf;
            end else begin
               bus.fifo_data_out  = 16'hDEAD;
               bus.fifo_underflow = 1'b1;
            end
         end else begin
            bus.fifo_underflow = 1'b0;
         end
         bus.fifo_empty = hold_empty || (fifo_q.size() == 0);
      end
   end

   // Stream monitor: collects transfers and flags any change while stalled.
   int          cyc       = 0;
   int          stall_err = 0;
   logic [15:0] rx_q[$];
   int          pop_cyc_q[$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data  = '0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!bus.m_valid || (bus.m_data !== prev_data))) stall_err++;
         if (bus.m_valid && bus.m_ready) begin
            rx_q.push_back(bus.m_data);
            pop_cyc_q.push_back(cyc);
         end
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
      end
   end

   logic [15:0] exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clear_logs();
      rx_q.delete();
      exp_q.delete();
      pop_cyc_q.delete();
   endtask

   task automatic load(input logic [15:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(first + 16'(i));
         exp_q.push_back(first + 16'(i));
      end
   endtask

   task automatic wait_rx(input int n, input int budget, input string tag);
      int k = 0;
      while ((rx_q.size() < n) && (k < budget)) begin
         tick();
         k++;
      end
      check(tag, rx_q.size(), n);
   endtask

   function automatic int rx_mismatches();
      int m = 0;
      if (rx_q.size() != exp_q.size()) m++;
      for (int i = 0; (i < rx_q.size()) && (i < exp_q.size()); i++)
         if (rx_q[i] !== exp_q[i]) m++;
      return m;
   endfunction

   int n_rd;
   int n_nv;

   initial begin
      rst_n       = 1'b0;
      enable      = 1'b0;
      bus.m_ready = 1'b0;

      // Reset values
      #2;
      check("rst_rd_en",   bus.fifo_rd_en, 0);
      check("rst_m_valid", bus.m_valid,    0);
      check("rst_m_data",  bus.m_data,     0);
      check("rst_rd_count", rd_count,      0);
      check("rst_err",     err_underflow,  0);
      check("rst_busy",    busy,           0);

      // Preloaded 0x0001..0x0008 streamed back to back
      clear_logs();
      load(16'h0001, 8);
      tick();
      tick();
      rst_n       = 1'b1;
      enable      = 1'b1;
      bus.m_ready = 1'b1;
      settle();
      check("t1_idle_no_read", bus.fifo_rd_en, 0);
      check("t1_idle_busy",    busy,           0);
      tick();
      settle();
      check("t1_first_read", bus.fifo_rd_en, 1);
      check("t1_run_busy",   busy,           1);
      wait_rx(8, 30, "t1_words_rx");
      repeat (3) tick();
      for (int i = 0; i < 8; i++) check("t1_word", rx_q[i], 16'(i + 1));
      check("t1_consecutive", pop_cyc_q[7] - pop_cyc_q[0], 7);
      check("t1_rd_count",    rd_count,    8);
      check("t1_busy_after",  busy,        1);
      check("t1_drained",     bus.m_valid, 0);

      // Sink stalls for 5 cycles mid-stream
      clear_logs();
      load(16'h0010, 16);
      repeat (3) tick();
      bus.m_ready = 1'b0;
      n_rd = 0;
      n_nv = 0;
      repeat (5) begin
         settle();
         if (bus.fifo_rd_en) n_rd++;
         if (!bus.m_valid)   n_nv++;
         tick();
      end
      bus.m_ready = 1'b1;
      check("t2_no_read_while_full", n_rd, 0);
      check("t2_valid_held",         n_nv, 0);
      wait_rx(16, 60, "t2_words_rx");
      check("t2_order", rx_mismatches(), 0);
      repeat (4) tick();
      check("t2_rd_count", rd_count, 24);

      // enable dropped with two reads outstanding
      clear_logs();
      load(16'h0021, 4);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      tick();
      tick();
      enable = 1'b0;
      settle();
      check("t3_no_read_after_disable", bus.fifo_rd_en, 0);
      check("t3_busy_draining",         busy,           1);
      tick();
      settle();
      check("t3_stop_busy", busy, 1);
      tick();
      tick();
      settle();
      check("t3_idle",          busy,           0);
      check("t3_idle_no_read",  bus.fifo_rd_en, 0);
      check("t3_words",         rx_mismatches(), 0);
      check("t3_left_in_fifo",  fifo_q.size(),  2);
      check("t3_rd_count",      rd_count,       26);
      fifo_q.delete();
      tick();

      // Underflow response on the first of two reads
      clear_logs();
      tick();
      fifo_q.push_back(16'h0031);
      fifo_q.push_back(16'h0032);
      exp_q.push_back(16'h0032);
      force_uf = 1'b1;
      enable   = 1'b1;
      tick();
      tick();
      tick();
      force_uf = 1'b0;
      settle();
      check("t4_err_set",      err_underflow, 1);
      check("t4_word_dropped", bus.m_valid,   0);
      check("t4_count_held",   rd_count,      26);
      tick();
      settle();
      check("t4_next_word", bus.m_data, 16'h0032);
      repeat (4) tick();
      settle();
      check("t4_err_sticky", err_underflow,   1);
      check("t4_rd_count",   rd_count,        27);
      check("t4_words",      rx_mismatches(), 0);

      // fifo_empty high blocks a read that would otherwise issue
      tick();
      hold_empty = 1'b1;
      fifo_q.push_back(16'h0033);
      exp_q.push_back(16'h0033);
      settle();
      check("t5_empty_blocks_read", bus.fifo_rd_en, 0);
      tick();
      hold_empty = 1'b0;
      settle();
      check("t5_read_when_nonempty", bus.fifo_rd_en, 1);
      wait_rx(2, 20, "t5_words_rx");
      repeat (3) tick();
      check("t5_rd_count", rd_count,        28);
      check("t5_words",    rx_mismatches(), 0);

      // Asynchronous reset with a full buffer
      clear_logs();
      bus.m_ready = 1'b0;
      load(16'h0041, 3);
      repeat (6) tick();
      settle();
      check("t6_valid_before_reset", bus.m_valid, 1);
      check("t6_head_before_reset",  bus.m_data,  16'h0041);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_m_valid",  bus.m_valid,    0);
      check("t6_rst_m_data",   bus.m_data,     0);
      check("t6_rst_rd_count", rd_count,       0);
      check("t6_rst_err",      err_underflow,  0);
      check("t6_rst_busy",     busy,           0);
      check("t6_rst_rd_en",    bus.fifo_rd_en, 0);
      fifo_q.delete();
      enable = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      settle();
      check("t6_no_stale_word", bus.m_valid, 0);
      check("t6_idle_busy",     busy,        0);

      // rd_count wraps 0xFFFF -> 0x0000
      tick();
      clear_logs();
      bus.m_ready = 1'b1;
      load(16'h0000, 65534);
      enable = 1'b1;
      wait_rx(65534, 66000, "t7_bulk_rx");
      repeat (3) tick();
      check("t7_count_fffe", rd_count, 16'hFFFE);
      load(16'hA000, 3);
      wait_rx(65537, 20, "t7_wrap_rx");
      repeat (3) tick();
      check("t7_count_wrapped", rd_count,        16'h0001);
      check("t7_order",         rx_mismatches(), 0);
      check("stall_stability",  stall_err,       0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter: FIFO_WIDTH, default 16 (taken from Shared_pkg), data word width.
REQ-002 Parameter: BUF_DEPTH, fixed 2, output buffer entries; other values unsupported.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  high = drain FIFO; low = stop issuing reads.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_underflow  input  1  FIFO underflow response, valid in the cycle after a read.
REQ-008 fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid in the cycle after rd_en.
REQ-009 fifo_rd_en  output  1  read request to FIFO.
REQ-010 m_data  output  FIFO_WIDTH  stream data, head of output buffer.
REQ-011 m_valid  output  1  stream valid.
REQ-012 m_ready  input  1  stream ready from sink.
REQ-013 rd_count  output  16  count of completed stream transfers.
REQ-014 err_underflow  output  1  sticky underflow error.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FIFO read latency is exactly 1 cycle: rd_en at cycle t -> fifo_data_out/fifo_underflow sampled at t+1.
REQ-017 inflight register = fifo_rd_en delayed one cycle.
REQ-018 pop = m_valid && m_ready; occ = output buffer occupancy (0..2).
REQ-019 fifo_rd_en = (state==RUN) && enable && !fifo_empty && (occ + inflight - pop < 2), combinational.
REQ-020 When inflight && !fifo_underflow, fifo_data_out is written to the buffer tail in that cycle.
REQ-021 When inflight && fifo_underflow, data is discarded and err_underflow set; it stays set until reset.
REQ-022 The buffer is FIFO-ordered; m_valid = (occ != 0); m_data = head entry; push and pop in the same cycle keep occ unchanged.
REQ-023 m_data/m_valid are stable while m_valid && !m_ready.
REQ-024 Sustained throughput: one word per cycle when FIFO non-empty and m_ready held high.
REQ-025 occ never exceeds 2; a write into a full buffer is a design error (assertion).
REQ-026 rd_count increments on each pop and wraps 0xFFFF -> 0x0000.
REQ-027 States: IDLE, RUN, STOP.
REQ-028 IDLE -> RUN when enable=1.
REQ-029 RUN -> STOP when enable=0; no new reads are issued from that cycle.
REQ-030 STOP -> IDLE when inflight=0 and occ=0 (drained); STOP -> RUN when enable=1 again.
REQ-031 fifo_empty rising in the same cycle as a candidate read suppresses that read.

Reset
REQ-032 On rst_n low, immediately: state=IDLE, occ=0, inflight=0, fifo_rd_en=0, m_valid=0, m_data=0, rd_count=0, err_underflow=0, busy=0.
REQ-033 Reset mid-operation discards buffered and in-flight data; no stale word is presented after release.
REQ-034 The first read can issue in the first cycle after reset release in which enable=1 and fifo_empty=0, one cycle after entering RUN.

Structure
REQ-035 Shared_pkg holds FIFO_WIDTH and typedef reader_state_e {IDLE, RUN, STOP}.
REQ-036 The 2-entry buffer is a sub-module stream_skid_buf (push, pop, data, occ).
REQ-037 The block connects directly to the FIFO_IF DUT-side signals (rd_en, data_out, empty, underflow).

Verification
REQ-038 Reset, enable=1, FIFO preloaded 0x0001..0x0008, m_ready=1 -> 8 words in order on consecutive cycles, rd_count=8, busy=1.
REQ-039 m_ready low for 5 cycles mid-stream -> occ saturates at 2, fifo_rd_en=0, no loss or duplication, m_data stable.
REQ-040 enable dropped with 2 reads in flight -> STOP, the in-flight words are delivered, then IDLE with busy=0.
REQ-041 Forced fifo_underflow=1 after a read -> err_underflow=1 sticky, word discarded, rd_count unchanged.
REQ-042 rd_count preloaded near wrap (0xFFFE), 3 transfers -> rd_count=0x0001.
REQ-043 rst_n asserted with occ=2 -> m_valid=0, rd_count=0 asynchronously, before the next clk edge.
